// File: rtl/denise_colortable_ng.sv
// denise_colortable_ng: banked 24-bit colour table with LOCT writes, EHB, init sweep, bypass and host readback
module denise_colortable_ng #(
    parameter int BANK_W  = 3,
    parameter int RD_LAT  = 2,
    parameter int EHB_BIT = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk7_en,
    input  logic [8:1]  reg_address_in,
    input  logic [11:0] data_in,
    input  logic [2:0]  bank,
    input  logic        loct,
    input  logic [7:0]  select,
    input  logic [7:0]  bplxor,
    input  logic        ehb_en,
    output logic [23:0] rgb,
    input  logic        host_req,
    input  logic [7:0]  host_adr,
    output logic        host_ack,
    output logic [23:0] host_dat,
    output logic        init_busy
);
    localparam int AW = 5 + BANK_W;
    localparam int N  = 32 << BANK_W;

    typedef enum logic {INIT, RUN} st_t;
    typedef enum logic [1:0] {H_IDLE, H_RD, H_DAT, H_WAIT} hst_t;

    function automatic logic [23:0] pack(input logic [23:0] w);
        return {w[23:20], w[11:8], w[19:16], w[7:4], w[15:12], w[3:0]};
    endfunction

    logic [23:0]   mem_q [N];
    st_t           st_q, st_d;
    hst_t          hst_q, hst_d;
    logic [AW-1:0] cnt_q, cnt_d, hadr_q, hadr_d;
    logic [23:0]   host_dat_q, p1_q, p2_q, pw, c, merged, wdat;
    logic          e1_q, e2_q, pe, wr_hit, we, byp, hrd_go;
    logic [7:0]    wa_full, x;
    logic [AW-1:0] wa, ra, waddr;
    logic          unused_ok;

    assign unused_ok = ^{wa_full, x, host_adr, p2_q, e2_q};

    // main FSM state register: reset restarts the clear sweep from address 0
    always_ff @(posedge clk) begin
        if (reset) begin
            st_q  <= INIT;
            cnt_q <= '0;
        end else begin
            st_q  <= st_d;
            cnt_q <= cnt_d;
        end
    end

    // main FSM next state: sweep every address once, then run
    always_comb begin
        st_d  = st_q;
        cnt_d = cnt_q;
        if (st_q == INIT) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == AW'(N - 1)) st_d = RUN;
        end
    end

    // main FSM outputs
    always_comb begin
        init_busy = (st_q == INIT);
    end

    // write port and pixel index; the clear sweep owns the write port while busy
    always_comb begin
        x       = select ^ bplxor;
        ra      = ehb_en ? AW'(x[4:0]) : x[AW-1:0];
        wa_full = {bank, reg_address_in[5:1]};
        wa      = wa_full[AW-1:0];
        wr_hit  = clk7_en & ~init_busy & (reg_address_in[8:6] == 3'b110);
        merged  = loct ? {mem_q[wa][23:12], data_in} : {data_in, data_in};
        we      = (init_busy & ~reset) | wr_hit;
        waddr   = init_busy ? cnt_q : wa;
        wdat    = init_busy ? 24'h0 : merged;
        byp     = we & (waddr == ra);
    end

    // storage write
    always_ff @(posedge clk) begin
        if (we) mem_q[waddr] <= wdat;
    end

    // pixel pipeline: write-first bypass on stage 1, EHB flag travels alongside
    always_ff @(posedge clk) begin
        if (reset) begin
            p1_q <= '0;
            p2_q <= '0;
            e1_q <= 1'b0;
            e2_q <= 1'b0;
        end else begin
            p1_q <= init_busy ? 24'h0 : (byp ? wdat : mem_q[ra]);
            e1_q <= select[EHB_BIT] & ehb_en;
            p2_q <= p1_q;
            e2_q <= e1_q;
        end
    end

    // pixel output: pick pipeline depth, apply half-brite, blank during the sweep
    always_comb begin
        pw  = (RD_LAT == 2) ? p2_q : p1_q;
        pe  = (RD_LAT == 2) ? e2_q : e1_q;
        c   = pack(pw);
        rgb = init_busy ? 24'h0 : (pe ? {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]} : c);
    end

    // host FSM state register and readback data
    always_ff @(posedge clk) begin
        if (reset) begin
            hst_q      <= H_IDLE;
            hadr_q     <= '0;
            host_dat_q <= '0;
        end else begin
            hst_q      <= hst_d;
            hadr_q     <= hadr_d;
            host_dat_q <= hrd_go ? pack(mem_q[hadr_q]) : host_dat_q;
        end
    end

    // host FSM next state: bus writes always take priority over the host read
    always_comb begin
        hst_d  = hst_q;
        hadr_d = hadr_q;
        case (hst_q)
            H_IDLE: if (host_req & ~init_busy & ~host_ack) begin
                hst_d  = H_RD;
                hadr_d = host_adr[AW-1:0];
            end
            H_RD:   if (~wr_hit) hst_d = H_DAT;
            H_DAT:  hst_d = H_WAIT;
            H_WAIT: if (~host_req) hst_d = H_IDLE;
            default: hst_d = H_IDLE;
        endcase
    end

    // host FSM outputs
    always_comb begin
        hrd_go   = (hst_q == H_RD) & ~wr_hit;
        host_ack = (hst_q == H_DAT);
        host_dat = host_dat_q;
    end
endmodule

// File: tb/tb_denise_colortable_ng.sv
// tb_denise_colortable_ng: directed checks of the colour table with default parameters
module tb_denise_colortable_ng;
    localparam int RD_LAT = 2;

    logic        clk = 1'b0, reset = 1'b1, clk7_en = 1'b0, loct = 1'b0, ehb_en = 1'b0, host_req = 1'b0;
    logic [7:0]  reg_address_in = '0, select = '0, bplxor = '0, host_adr = '0;
    logic [11:0] data_in = '0;
    logic [2:0]  bank = '0;
    logic [23:0] rgb, host_dat;
    logic        host_ack, init_busy;
    int          checks = 0, errors = 0, acks = 0;

    always #5 clk = ~clk;

    denise_colortable_ng dut (
        .clk(clk), .reset(reset), .clk7_en(clk7_en), .reg_address_in(reg_address_in),
        .data_in(data_in), .bank(bank), .loct(loct), .select(select), .bplxor(bplxor),
        .ehb_en(ehb_en), .rgb(rgb), .host_req(host_req), .host_adr(host_adr),
        .host_ack(host_ack), .host_dat(host_dat), .init_busy(init_busy)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic wr(input logic [2:0] b, input logic [7:0] a, input logic [11:0] d, input logic lo);
        bank = b;
        reg_address_in = a;
        data_in = d;
        loct = lo;
        clk7_en = 1'b1;
        step;
        clk7_en = 1'b0;
    endtask

    task automatic pix(input string tag, input logic [7:0] s, input logic [7:0] xv, input logic e, input logic [23:0] exp);
        select = s;
        bplxor = xv;
        ehb_en = e;
        repeat (RD_LAT) step;
        chk(tag, rgb, exp);
    endtask

    task automatic init_run(input string tag, output int ack_cnt);
        int   n = 0;
        logic bad = 1'b0;
        ack_cnt = 0;
        while (init_busy && n < 1000) begin
            if (rgb !== 24'h0) bad = 1'b1;
            if (host_ack) ack_cnt++;
            n++;
            step;
        end
        chk({tag, "_len"}, n, 256);
        chk({tag, "_rgb0"}, {31'b0, bad}, 0);
    endtask

    task automatic wait_ack(input string tag);
        for (int i = 0; i < 20 && !host_ack; i++) step;
        chk(tag, {31'b0, host_ack}, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        repeat (3) step;
        chk("rst_rgb", rgb, 0);
        chk("rst_ack", {31'b0, host_ack}, 0);
        chk("rst_hdat", host_dat, 0);
        chk("rst_busy", {31'b0, init_busy}, 1);
        reset = 1'b0;
        init_run("init", acks);

        host_adr = 8'h10;
        host_req = 1'b1;
        wait_ack("h0_ack");
        chk("h0_dat", host_dat, 24'h000000);
        host_req = 1'b0;
        repeat (2) step;

        wr(3'd0, 8'hC1, 12'hF84, 1'b0);
        pix("wr_full", 8'h01, 8'h00, 1'b0, 24'hFF8844);
        wr(3'd0, 8'hC1, 12'h123, 1'b1);
        pix("wr_loct", 8'h01, 8'h00, 1'b0, 24'hF18243);

        wr(3'd0, 8'hC3, 12'hF84, 1'b0);
        pix("ehb_clear", 8'h03, 8'h00, 1'b1, 24'hFF8844);
        select = 8'h23;
        step;
        chk("ehb_lat", rgb, 24'hFF8844);
        step;
        chk("ehb_on", rgb, 24'h7F4422);

        wr(3'd5, 8'hCF, 12'h0F0, 1'b0);
        pix("bank", 8'h5F, 8'hF0, 1'b0, 24'h00FF00);
        pix("bank_ehb", 8'h5F, 8'hF0, 1'b1, 24'h000000);
        host_adr = 8'hAF;
        host_req = 1'b1;
        wait_ack("hbank_ack");
        chk("hbank_dat", host_dat, 24'h00FF00);
        host_req = 1'b0;
        repeat (2) step;

        bank = 3'd0;
        reg_address_in = 8'hC4;
        data_in = 12'hABC;
        loct = 1'b0;
        clk7_en = 1'b1;
        select = 8'h04;
        bplxor = 8'h00;
        ehb_en = 1'b0;
        step;
        clk7_en = 1'b0;
        step;
        chk("bypass", rgb, 24'hAABBCC);

        host_adr = 8'h01;
        reg_address_in = 8'hC1;
        data_in = 12'h5A5;
        clk7_en = 1'b1;
        host_req = 1'b1;
        step;
        chk("h_wr_ack0", {31'b0, host_ack}, 0);
        data_in = 12'h777;
        step;
        clk7_en = 1'b0;
        chk("h_blocked", {31'b0, host_ack}, 0);
        step;
        chk("h_ack", {31'b0, host_ack}, 1);
        chk("h_dat", host_dat, 24'h777777);
        acks = 0;
        repeat (6) begin
            step;
            if (host_ack) acks++;
        end
        chk("h_one_ack", acks, 0);
        chk("h_hold", host_dat, 24'h777777);
        pix("h_pix", 8'h01, 8'h00, 1'b0, 24'h777777);

        host_req = 1'b0;
        step;
        reg_address_in = 8'hC2;
        data_in = 12'hFFF;
        clk7_en = 1'b1;
        host_req = 1'b1;
        step;
        step;
        chk("hrd_ack0", {31'b0, host_ack}, 0);
        reset = 1'b1;
        step;
        reset = 1'b0;
        chk("rst2_busy", {31'b0, init_busy}, 1);
        init_run("init2", acks);
        clk7_en = 1'b0;
        chk("rst2_no_ack", acks, 0);
        wait_ack("rst2_ack");
        chk("rst2_dat", host_dat, 24'h000000);
        host_req = 1'b0;
        pix("wr_dropped", 8'h02, 8'h00, 1'b0, 24'h000000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
